// File: rtl/bp_be_issue_queue_if.sv
// Handshake bundle for the speculative issue queue: enqueue, speculative read,
// commit, rollback and clear.
interface bp_be_issue_queue_if #(
    parameter int unsigned width_p = 128,
    parameter int unsigned els_p   = 8
);
    localparam int unsigned ptr_width_lp = $clog2(els_p) + 1;

    logic [width_p-1:0]      data_i;
    logic                    v_i;
    logic                    ready_o;
    logic [width_p-1:0]      data_o;
    logic                    v_o;
    logic                    yumi_i;
    logic                    deq_i;
    logic                    roll_i;
    logic                    clr_i;
    logic [ptr_width_lp-1:0] count_o;

    modport slave (
        input  data_i, v_i, yumi_i, deq_i, roll_i, clr_i,
        output ready_o, data_o, v_o, count_o
    );

    modport master (
        output data_i, v_i, yumi_i, deq_i, roll_i, clr_i,
        input  ready_o, data_o, v_o, count_o
    );
endinterface

// File: rtl/bp_be_issue_queue.sv
// Issue queue with three pointers: write, speculative read and commit. Reads are
// speculative until committed with deq; roll rewinds reads, clr drops uncommitted entries.
module bp_be_issue_queue #(
    parameter int unsigned width_p = 128,
    parameter int unsigned els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    bp_be_issue_queue_if.slave q
);
    localparam int unsigned idx_width_lp = $clog2(els_p);
    localparam int unsigned ptr_width_lp = idx_width_lp + 1;

    typedef logic [ptr_width_lp-1:0] ptr_t;

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t cptr_q, cptr_d;
    ptr_t count;
    logic ready;
    logic enq;
    logic we;

    logic [width_p-1:0] mem [els_p];

    // Pointers carry one extra wrap bit, so plain subtraction gives 0..els_p.
    assign count     = wptr_q - cptr_q;
    assign ready     = (count != ptr_t'(els_p));
    assign q.count_o = count;
    assign q.ready_o = ready;
    assign q.v_o     = (rptr_q != wptr_q);
    assign q.data_o  = mem[rptr_q[idx_width_lp-1:0]];

    always_comb begin
        cptr_d = cptr_q + ptr_t'(q.deq_i);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        enq    = q.v_i & ready;
        we     = 1'b0;
        // deq is folded in before clr/roll so both rewind to the post-commit point.
        if (q.clr_i) begin
            wptr_d = cptr_d;
            rptr_d = cptr_d;
        end else begin
            if (enq) begin
                wptr_d = wptr_q + ptr_t'(1);
                we     = 1'b1;
            end
            if (q.roll_i) begin
                rptr_d = cptr_d;
            end else if (q.yumi_i) begin
                rptr_d = rptr_q + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    // Storage is not reset; writes are blocked while reset is held.
    always_ff @(posedge clk_i) begin
        if (we && !reset_i) begin
            mem[wptr_q[idx_width_lp-1:0]] <= q.data_i;
        end
    end

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        q.yumi_i |-> q.v_o);

    deq_needs_read: assert property (@(posedge clk_i) disable iff (reset_i)
        q.deq_i |-> (cptr_q != rptr_q));
endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Directed bench for bp_be_issue_queue (els_p=4, width_p=8); speculative reads are
// checked by a scoreboard monitor, status outputs by inline checks.
module tb_bp_be_issue_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    bp_be_issue_queue_if #(.width_p(8), .els_p(4)) q ();

    bp_be_issue_queue #(.width_p(8), .els_p(4)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .q       (q)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every consumed speculative read must match the next expected entry.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset && q.yumi_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got 0x%0h, expected no read", q.data_o);
            end else begin
                e = exp_q.pop_front();
                check("read_valid", 32'(q.v_o), 32'd1);
                check("read_data", 32'(q.data_o), 32'(e));
            end
        end
    end

    task automatic clear_in();
        q.v_i    = 1'b0;
        q.data_i = '0;
        q.yumi_i = 1'b0;
        q.deq_i  = 1'b0;
        q.roll_i = 1'b0;
        q.clr_i  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic enq(input logic [7:0] d);
        q.v_i    = 1'b1;
        q.data_i = d;
        tick();
    endtask

    task automatic rd(input logic [7:0] d, input logic with_deq);
        exp_q.push_back(d);
        q.yumi_i = 1'b1;
        q.deq_i  = with_deq;
        tick();
    endtask

    task automatic status(input string name, input int cnt, input logic rdy, input logic v);
        check({name, "_count"}, 32'(q.count_o), 32'(cnt));
        check({name, "_ready"}, 32'(q.ready_o), 32'(rdy));
        check({name, "_v"}, 32'(q.v_o), 32'(v));
    endtask

    initial begin
        clear_in();
        @(posedge clk);
        #1;
        status("reset", 0, 1'b1, 1'b0);
        tick();
        reset = 1'b0;

        // Fill to full; the fifth enqueue must be refused.
        enq(8'h11); enq(8'h22); enq(8'h33); enq(8'h44);
        q.v_i = 1'b1; q.data_i = 8'h55; tick();
        status("full", 4, 1'b0, 1'b1);
        check("full_head", 32'(q.data_o), 32'h11);

        // Speculate three reads, then rewind.
        rd(8'h11, 1'b0); rd(8'h22, 1'b0); rd(8'h33, 1'b0);
        check("spec_head", 32'(q.data_o), 32'h44);
        q.roll_i = 1'b1; tick();
        status("roll", 4, 1'b0, 1'b1);
        check("roll_head", 32'(q.data_o), 32'h11);

        // Commit two, refill across the wrap point.
        rd(8'h11, 1'b0); rd(8'h22, 1'b1);
        q.deq_i = 1'b1; tick();
        status("commit", 2, 1'b1, 1'b1);
        enq(8'h55); enq(8'h66);
        status("wrap", 4, 1'b0, 1'b1);
        check("wrap_wptr", 32'(dut.wptr_q), 32'b110);
        rd(8'h33, 1'b0); rd(8'h44, 1'b1); rd(8'h55, 1'b1); rd(8'h66, 1'b1);
        q.deq_i = 1'b1; tick();
        status("drained", 0, 1'b1, 1'b0);

        // clr + deq + enqueue together: everything uncommitted vanishes.
        enq(8'hA0); enq(8'hA1); enq(8'hA2);
        rd(8'hA0, 1'b0); rd(8'hA1, 1'b0);
        check("pre_clr_head", 32'(q.data_o), 32'hA2);
        q.deq_i = 1'b1; q.clr_i = 1'b1; q.v_i = 1'b1; q.data_i = 8'hB0; tick();
        status("clr", 0, 1'b1, 1'b0);
        enq(8'hD0);
        check("post_clr_head", 32'(q.data_o), 32'hD0);
        rd(8'hD0, 1'b0);
        q.deq_i = 1'b1; tick();

        // roll with a same-cycle enqueue keeps the new entry behind the rewound ones.
        enq(8'hE0); enq(8'hE1);
        rd(8'hE0, 1'b0); rd(8'hE1, 1'b0);
        check("pre_roll_v", 32'(q.v_o), 32'd0);
        q.roll_i = 1'b1; q.v_i = 1'b1; q.data_i = 8'hC0; tick();
        status("roll_enq", 3, 1'b1, 1'b1);
        check("roll_enq_head", 32'(q.data_o), 32'hE0);
        rd(8'hE0, 1'b0); rd(8'hE1, 1'b1); rd(8'hC0, 1'b1);
        q.deq_i = 1'b1; tick();
        status("empty", 0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with three entries queued.
        enq(8'hF0); enq(8'hF1); enq(8'hF2);
        check("pre_reset_count", 32'(q.count_o), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        status("async_reset", 0, 1'b1, 1'b0);
        q.v_i = 1'b1; q.data_i = 8'h99;
        @(posedge clk);
        #1;
        clear_in();
        status("held_reset", 0, 1'b1, 1'b0);
        reset = 1'b0;
        enq(8'h77);
        status("post_reset", 1, 1'b1, 1'b1);
        check("post_reset_head", 32'(q.data_o), 32'h77);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bp_be_issue_queue.md
BP_BE_ISSUE_QUEUE -- requirements
Module: bp_be_issue_queue

Interface
REQ-001 SHALL have parameter width_p, default 128, entry width in bits.
REQ-002 SHALL have parameter els_p, default 8, entry count; must be a power of 2 and at least 2.
REQ-003 SHALL define ptr_width_lp = log2(els_p)+1, i.e. an index plus a wrap bit.
REQ-004 SHALL have port clk_i, input, 1, the single clock, rising edge.
REQ-005 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port data_i, input, width_p, enqueue data.
REQ-007 SHALL have port v_i, input, 1, enqueue valid.
REQ-008 SHALL have port ready_o, output, 1, enqueue space available.
REQ-009 SHALL have port data_o, output, width_p, entry at the speculative read pointer.
REQ-010 SHALL have port v_o, output, 1, data_o valid.
REQ-011 SHALL have port yumi_i, input, 1, speculative read consumed.
REQ-012 SHALL have port deq_i, input, 1, commit (free) the oldest entry.
REQ-013 SHALL have port roll_i, input, 1, rewind the speculative read pointer to the commit pointer.
REQ-014 SHALL have port clr_i, input, 1, discard all uncommitted entries.
REQ-015 SHALL have port count_o, output, ptr_width_lp, occupancy counted from commit pointer to write pointer.

Function
REQ-016 SHALL hold three registered pointers, wptr, rptr and cptr, each ptr_width_lp wide, with the invariant cptr <= rptr <= wptr in modular order.
REQ-017 SHALL drive count_o = wptr - cptr modulo 2^ptr_width_lp, with range 0..els_p.
REQ-018 SHALL drive ready_o = (count_o != els_p), combinationally from registers only.
REQ-019 SHALL drive v_o = (rptr != wptr), combinationally from registers only.
REQ-020 SHALL drive data_o = mem[rptr index] via asynchronous read; data_o is don't-care when v_o=0.
REQ-021 SHALL, when v_i & ready_o, write data_i at wptr and increment wptr; the entry becomes visible on data_o the next cycle, with no same-cycle bypass.
REQ-022 SHALL ignore v_i when ready_o=0: no write and no pointer change.
REQ-023 SHALL increment rptr on yumi_i; yumi_i with v_o=0 is illegal and SHALL fire an assertion.
REQ-024 SHALL increment cptr on deq_i; deq_i with cptr==rptr is illegal and SHALL fire an assertion.
REQ-025 SHALL evaluate events in this priority order: clr_i > roll_i > yumi_i; deq_i and enqueue are evaluated independently.
REQ-026 SHALL apply deq_i before clr_i/roll_i in the same cycle, so the effective commit pointer is cptr_n = cptr + deq_i.
REQ-027 SHALL, on clr_i, set wptr <= cptr_n and rptr <= cptr_n; a same-cycle enqueue is dropped and yumi_i is ignored.
REQ-028 SHALL, on roll_i without clr_i, set rptr <= cptr_n; a same-cycle yumi_i is ignored and a same-cycle enqueue is accepted.
REQ-029 SHALL let a same-cycle enqueue and deq_i at full both complete only if ready_o was already 1; ready_o is not a function of deq_i.
REQ-030 SHALL wrap pointer index bits modulo els_p and toggle the wrap bit on each wrap.
REQ-031 SHALL impose zero latency from roll_i/clr_i to pointer update: the new v_o and data_o appear the next cycle.

Reset
REQ-032 SHALL, while reset_i=1, asynchronously clear wptr, rptr and cptr to 0.
REQ-033 SHALL, while reset_i=1, drive v_o=0, ready_o=1 and count_o=0.
REQ-034 SHALL not reset memory contents.
REQ-035 SHALL, on reset asserted mid-operation, discard every entry, committed or not, with no further writes until reset deasserts.

Verification (els_p=4, width_p=8)
REQ-036 SHALL verify fill/full: enqueue 0x11,0x22,0x33,0x44 on consecutive cycles, then present 0x55 -> count_o=4, ready_o=0, 0x55 not stored, data_o=0x11.
REQ-037 SHALL verify speculate/roll: after REQ-036, yumi 3 cycles, then roll_i -> data_o=0x11, count_o=4, v_o=1.
REQ-038 SHALL verify commit/wrap: yumi+deq 0x11 and 0x22, then enqueue 0x55,0x66 -> count_o=4, wptr index wrapped to 2 with wrap bit 1; subsequent reads return 0x33,0x44,0x55,0x66.
REQ-039 SHALL verify simultaneous clr+deq+enqueue: entries 0xA0,0xA1,0xA2, rptr at 0xA2, cptr at 0xA0; assert deq_i, clr_i and v_i with 0xB0 -> next cycle count_o=0, v_o=0, 0xB0 dropped.
REQ-040 SHALL verify roll+enqueue: 2 entries both yumi'd, none committed; roll_i with v_i 0xC0 -> count_o=3, data_o equals first entry, and 0xC0 is read third.
REQ-041 SHALL verify async reset: assert reset_i mid-cycle with 3 entries -> v_o=0, ready_o=1, count_o=0 before the next clk_i edge.
